decode_hazard_unit: RTL and testbench

DECODE_HAZARD_UNIT -- requirements
Module: decode_hazard_unit

---
 rtl/decode_hazard_unit_pkg.sv | 18 +
 rtl/decode_regfile.sv | 32 +++
 rtl/decode_hazard_unit.sv | 123 ++++++++++++
 tb/tb_decode_hazard_unit.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/decode_hazard_unit_pkg.sv
// Shared definitions for the decode/hazard slice: default widths, if_ctl bit
// positions and the {we, is_load, rd} layout of ex_info/mem_info.
package decode_hazard_unit_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int AW_DEF     = 6;

    // if_ctl = {use_rs1, use_rs2, is_branch, branch_ne}
    localparam int CTL_USE_RS1   = 3;
    localparam int CTL_USE_RS2   = 2;
    localparam int CTL_IS_BRANCH = 1;
    localparam int CTL_BRANCH_NE = 0;

    // ex_info/mem_info = {we, is_load, rd}; rd sits in [AW-1:0], the flag
    // offsets below are relative to bit AW.
    localparam int INFO_RD_LSB  = 0;
    localparam int INFO_LD_OFS  = 0;
    localparam int INFO_WE_OFS  = 1;
endpackage

// File: rtl/decode_regfile.sv
// Register file: two combinational read ports, one clocked write port,
// every entry cleared by the asynchronous reset.
import decode_hazard_unit_pkg::*;

module decode_regfile #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int AW     = AW_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic [AW-1:0]     raddr2,
    output logic [DATA_W-1:0] rdata2
);
    logic [DATA_W-1:0] mem [2**AW];

    // clear on reset, otherwise write the writeback port when enabled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2**AW; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata1 = mem[raddr1];
    assign rdata2 = mem[raddr2];
endmodule

// File: rtl/decode_hazard_unit.sv
// ID stage: IF/ID register, operand forwarding, load-use / branch hazard
// detection and branch resolution.
// Optional: define DECODE_STALL_CNT_EN to add a saturating hazard-cycle
// counter on output stall_cnt.
import decode_hazard_unit_pkg::*;

module decode_hazard_unit #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int AW     = AW_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              ex_stall,
    input  logic              if_valid,
    input  logic [31:0]       if_instr,
    input  logic [3*AW-1:0]   if_regs,
    input  logic [3:0]        if_ctl,
    input  logic [DATA_W-1:0] if_pc4,
    input  logic              wb_we,
    input  logic [AW-1:0]     wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [AW+1:0]     ex_info,
    input  logic [AW+1:0]     mem_info,
    input  logic [DATA_W-1:0] mem_data,
    output logic              if_hold,
    output logic              id_valid,
    output logic [31:0]       id_instr,
    output logic [3*AW-1:0]   id_regs,
    output logic [DATA_W-1:0] id_pc4,
    output logic [DATA_W-1:0] id_op1,
    output logic [DATA_W-1:0] id_op2,
    output logic              br_taken
`ifdef DECODE_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);
    logic              vld;
    logic [3:0]        ctl;
    logic              hazard;
    logic [AW-1:0]     rs1, rs2;
    logic [DATA_W-1:0] rf1, rf2;

    assign rs1 = id_regs[3*AW-1:2*AW];
    assign rs2 = id_regs[2*AW-1:AW];

    wire           ex_we   = ex_info[AW+INFO_WE_OFS];
    wire           ex_ld   = ex_info[AW+INFO_LD_OFS];
    wire [AW-1:0]  ex_rd   = ex_info[INFO_RD_LSB +: AW];
    wire           mem_we  = mem_info[AW+INFO_WE_OFS];
    wire           mem_ld  = mem_info[AW+INFO_LD_OFS];
    wire [AW-1:0]  mem_rd  = mem_info[INFO_RD_LSB +: AW];
    wire           is_br   = ctl[CTL_IS_BRANCH];

    // IF/ID register: flush beats hold; a hazard or downstream stall holds
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld      <= 1'b0;
            id_instr <= '0;
            id_regs  <= '0;
            ctl      <= '0;
            id_pc4   <= '0;
        end else if (flush || !(hazard || ex_stall)) begin
            vld      <= if_valid && !flush;
            id_instr <= if_instr;
            id_regs  <= if_regs;
            ctl      <= if_ctl;
            id_pc4   <= if_pc4;
        end
    end

    decode_regfile #(.DATA_W(DATA_W), .AW(AW)) u_rf (
        .clk    (clk),
        .reset  (reset),
        .we     (wb_we),
        .waddr  (wb_addr),
        .wdata  (wb_data),
        .raddr1 (rs1),
        .rdata1 (rf1),
        .raddr2 (rs2),
        .rdata2 (rf2)
    );

    // MEM ALU results are newest, then the writeback bypass, then the file;
    // loads in MEM have no data yet and are covered by the hazard logic
    function automatic logic [DATA_W-1:0] fwd(input logic [AW-1:0] rs,
                                              input logic [DATA_W-1:0] rf);
        if (rs == '0)                               return '0;
        else if (mem_we && !mem_ld && mem_rd == rs) return mem_data;
        else if (wb_we && wb_addr == rs)            return wb_data;
        else                                        return rf;
    endfunction

    // branches compare in ID, so any EX producer or a MEM load stalls them;
    // other instructions stall only on a load in EX
    function automatic logic src_haz(input logic [AW-1:0] rs, input logic use_rs);
        logic hit;
        hit = (ex_we && ex_ld && ex_rd == rs)
           || (is_br && ex_we && ex_rd == rs)
           || (is_br && mem_we && mem_ld && mem_rd == rs);
        return vld && use_rs && (rs != '0) && hit;
    endfunction

    // operand selection and hazard detection
    always_comb begin
        id_op1 = fwd(rs1, rf1);
        id_op2 = fwd(rs2, rf2);
        hazard = src_haz(rs1, ctl[CTL_USE_RS1]) || src_haz(rs2, ctl[CTL_USE_RS2]);
    end

    assign if_hold  = (hazard || ex_stall) && !reset;
    assign id_valid = vld && !hazard;
    assign br_taken = id_valid && is_br && ((id_op1 == '0) ^ ctl[CTL_BRANCH_NE]);

`ifdef DECODE_STALL_CNT_EN
    // count hazard cycles, sticking at all-ones
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                          stall_cnt <= '0;
        else if (hazard && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_decode_hazard_unit.sv
// Directed bench for decode_hazard_unit: reset, load-use, branch-on-load,
// forwarding, full-width branch compare, flush vs hazard, ex_stall hold,
// and reset in the middle of a stall.
module tb_decode_hazard_unit;
    localparam int DW = 32;
    localparam int AW = 6;

    logic            clk = 1'b0;
    logic            reset, flush, ex_stall, if_valid, wb_we;
    logic [31:0]     if_instr;
    logic [3*AW-1:0] if_regs;
    logic [3:0]      if_ctl;
    logic [DW-1:0]   if_pc4, wb_data, mem_data;
    logic [AW-1:0]   wb_addr;
    logic [AW+1:0]   ex_info, mem_info;
    logic            if_hold, id_valid, br_taken;
    logic [31:0]     id_instr;
    logic [3*AW-1:0] id_regs;
    logic [DW-1:0]   id_pc4, id_op1, id_op2;

    int passed = 0;
    int total  = 0;

    decode_hazard_unit #(.DATA_W(DW), .AW(AW)) dut (
        .clk(clk), .reset(reset), .flush(flush), .ex_stall(ex_stall),
        .if_valid(if_valid), .if_instr(if_instr), .if_regs(if_regs),
        .if_ctl(if_ctl), .if_pc4(if_pc4), .wb_we(wb_we), .wb_addr(wb_addr),
        .wb_data(wb_data), .ex_info(ex_info), .mem_info(mem_info),
        .mem_data(mem_data), .if_hold(if_hold), .id_valid(id_valid),
        .id_instr(id_instr), .id_regs(id_regs), .id_pc4(id_pc4),
        .id_op1(id_op1), .id_op2(id_op2), .br_taken(br_taken)
    );

    always #5 clk = ~clk;

    function automatic logic [3*AW-1:0] mk_regs(input int a, input int b, input int c);
        return {a[AW-1:0], b[AW-1:0], c[AW-1:0]};
    endfunction

    function automatic logic [AW+1:0] mk_info(input logic we, input logic ld, input int rd);
        return {we, ld, rd[AW-1:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_if(input logic [31:0] ins, input logic [3*AW-1:0] r, input logic [3:0] c);
        if_valid = 1'b1; if_instr = ins; if_regs = r; if_ctl = c; if_pc4 = ins + 32'd4;
    endtask

    task automatic wb_write(input int a, input logic [DW-1:0] d);
        wb_we = 1'b1; wb_addr = a[AW-1:0]; wb_data = d;
        step();
        wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 0; ex_stall = 1'b1; if_valid = 0; if_instr = '0;
        if_regs = '0; if_ctl = '0; if_pc4 = '0; wb_we = 0; wb_addr = '0;
        wb_data = '0; ex_info = '0; mem_info = '0; mem_data = '0;
        #12;
        total++; if (if_hold !== 1'b0) $display("FAIL rst_hold: got %0b exp 0", if_hold); else passed++;
        total++; if (id_valid !== 1'b0) $display("FAIL rst_valid: got %0b exp 0", id_valid); else passed++;
        total++; if (br_taken !== 1'b0) $display("FAIL rst_br: got %0b exp 0", br_taken); else passed++;
        total++; if (id_pc4 !== 32'h0) $display("FAIL rst_pc4: got %h exp 0", id_pc4); else passed++;
        ex_stall = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_load_use();
        set_if(32'h1111_0001, mk_regs(5, 0, 1), 4'b1000);
        step();
        ex_info = mk_info(1, 1, 5);
        set_if(32'h2222_0002, mk_regs(0, 0, 2), 4'b0000);
        #1;
        total++; if (if_hold !== 1'b1) $display("FAIL lu_hold: got %0b exp 1", if_hold); else passed++;
        total++; if (id_valid !== 1'b0) $display("FAIL lu_bubble: got %0b exp 0", id_valid); else passed++;
        step();
        ex_info = '0; mem_info = mk_info(1, 1, 5);
        #1;
        total++; if (if_hold !== 1'b0) $display("FAIL lu_release: got %0b exp 0", if_hold); else passed++;
        total++; if (id_valid !== 1'b1) $display("FAIL lu_issue: got %0b exp 1", id_valid); else passed++;
        total++; if (id_instr !== 32'h1111_0001) $display("FAIL lu_instr: got %h exp 11110001", id_instr); else passed++;
        step();
        mem_info = '0;
        #1;
        total++; if (id_instr !== 32'h2222_0002) $display("FAIL lu_next: got %h exp 22220002", id_instr); else passed++;
    endtask

    task automatic test_branch_load();
        if_valid = 0;
        wb_write(7, 32'd5);
        set_if(32'h3333_0003, mk_regs(7, 0, 0), 4'b1010);
        step();
        ex_info = mk_info(1, 1, 7);
        set_if(32'h4444_0004, mk_regs(0, 0, 0), 4'b0000);
        #1;
        total++; if ({if_hold, id_valid, br_taken} !== 3'b100) $display("FAIL brl_stall1: got %b exp 100", {if_hold, id_valid, br_taken}); else passed++;
        step();
        ex_info = '0; mem_info = mk_info(1, 1, 7);
        #1;
        total++; if ({if_hold, id_valid, br_taken} !== 3'b100) $display("FAIL brl_stall2: got %b exp 100", {if_hold, id_valid, br_taken}); else passed++;
        step();
        mem_info = '0; wb_we = 1'b1; wb_addr = 6'd7; wb_data = '0;
        #1;
        total++; if ({if_hold, id_valid, br_taken} !== 3'b011) $display("FAIL brl_taken: got %b exp 011", {if_hold, id_valid, br_taken}); else passed++;
        total++; if (id_instr !== 32'h3333_0003) $display("FAIL brl_instr: got %h exp 33330003", id_instr); else passed++;
        step();
        wb_we = 1'b0; wb_addr = '0;
    endtask

    task automatic test_forwarding();
        if_valid = 0;
        wb_write(3, 32'h0000_AAAA);
        set_if(32'h5555_0005, mk_regs(3, 3, 8), 4'b1100);
        step();
        mem_info = mk_info(1, 0, 3); mem_data = 32'h1234_5678;
        wb_we = 1'b1; wb_addr = 6'd3; wb_data = '0;
        #1;
        total++; if (id_op1 !== 32'h1234_5678) $display("FAIL fwd_mem_op1: got %h exp 12345678", id_op1); else passed++;
        total++; if (id_op2 !== 32'h1234_5678) $display("FAIL fwd_mem_op2: got %h exp 12345678", id_op2); else passed++;
        total++; if (id_valid !== 1'b1) $display("FAIL fwd_valid: got %0b exp 1", id_valid); else passed++;
        step();
        mem_info = '0; wb_we = 1'b0; wb_addr = '0;
        wb_write(3, 32'h0000_0077);
        #1;
        total++; if (id_op1 !== 32'h0000_0077) $display("FAIL fwd_rf: got %h exp 00000077", id_op1); else passed++;
        wb_we = 1'b1; wb_addr = 6'd3; wb_data = 32'h0000_0099;
        #1;
        total++; if (id_op1 !== 32'h0000_0099) $display("FAIL fwd_wb: got %h exp 00000099", id_op1); else passed++;
        wb_we = 1'b0; wb_addr = '0; wb_data = '0;
        set_if(32'h5555_0006, mk_regs(0, 3, 8), 4'b1100);
        step();
        mem_info = mk_info(1, 0, 0); mem_data = 32'h0000_DEAD;
        #1;
        total++; if (id_op1 !== 32'h0) $display("FAIL fwd_r0: got %h exp 0", id_op1); else passed++;
        mem_info = '0; mem_data = '0;
    endtask

    task automatic test_full_compare();
        if_valid = 0;
        wb_write(4, 32'h8000_0000);
        set_if(32'h6666_0001, mk_regs(4, 0, 0), 4'b1010);
        step();
        total++; if (id_op1 !== 32'h8000_0000) $display("FAIL fc_op1: got %h exp 80000000", id_op1); else passed++;
        total++; if (br_taken !== 1'b0) $display("FAIL fc_beqz: got %0b exp 0", br_taken); else passed++;
        set_if(32'h6666_0002, mk_regs(4, 0, 0), 4'b1011);
        step();
        total++; if (br_taken !== 1'b1) $display("FAIL fc_bnez: got %0b exp 1", br_taken); else passed++;
        set_if(32'h6666_0003, mk_regs(0, 0, 0), 4'b1010);
        step();
        total++; if (br_taken !== 1'b1) $display("FAIL fc_beqz_r0: got %0b exp 1", br_taken); else passed++;
    endtask

    task automatic test_flush_hazard();
        set_if(32'h7777_0001, mk_regs(5, 0, 1), 4'b1000);
        step();
        ex_info = mk_info(1, 1, 5); flush = 1'b1;
        #1;
        total++; if (if_hold !== 1'b1) $display("FAIL fl_hold_pre: got %0b exp 1", if_hold); else passed++;
        step();
        flush = 1'b0;
        #1;
        total++; if (id_valid !== 1'b0) $display("FAIL fl_valid: got %0b exp 0", id_valid); else passed++;
        total++; if (if_hold !== 1'b0) $display("FAIL fl_hold: got %0b exp 0", if_hold); else passed++;
        ex_info = '0;
    endtask

    task automatic test_ex_stall();
        set_if(32'h8888_0001, mk_regs(0, 0, 1), 4'b0000);
        step();
        ex_stall = 1'b1;
        set_if(32'h8888_0002, mk_regs(0, 0, 2), 4'b0000);
        #1;
        total++; if ({if_hold, id_valid} !== 2'b11) $display("FAIL st_hold: got %b exp 11", {if_hold, id_valid}); else passed++;
        step();
        total++; if (id_instr !== 32'h8888_0001) $display("FAIL st_held: got %h exp 88880001", id_instr); else passed++;
        ex_stall = 1'b0;
        step();
        total++; if (id_instr !== 32'h8888_0002) $display("FAIL st_adv: got %h exp 88880002", id_instr); else passed++;
    endtask

    task automatic test_reset_mid_stall();
        if_valid = 0;
        wb_write(9, 32'h0000_0055);
        set_if(32'h9999_0001, mk_regs(5, 0, 1), 4'b1000);
        step();
        ex_info = mk_info(1, 1, 5);
        #1;
        total++; if (if_hold !== 1'b1) $display("FAIL rms_stall: got %0b exp 1", if_hold); else passed++;
        reset = 1'b1;
        #1;
        total++; if ({if_hold, id_valid, br_taken} !== 3'b000) $display("FAIL rms_outs: got %b exp 000", {if_hold, id_valid, br_taken}); else passed++;
        total++; if (id_instr !== 32'h0) $display("FAIL rms_instr: got %h exp 0", id_instr); else passed++;
        ex_info = '0;
        set_if(32'h9999_0002, mk_regs(9, 0, 1), 4'b1000);
        #1;
        reset = 1'b0;
        step();
        total++; if (id_valid !== 1'b1) $display("FAIL rms_new_valid: got %0b exp 1", id_valid); else passed++;
        total++; if (id_op1 !== 32'h0) $display("FAIL rms_rf_clear: got %h exp 0", id_op1); else passed++;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_load();
        test_forwarding();
        test_full_compare();
        test_flush_hazard();
        test_ex_stall();
        test_reset_mid_stall();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
